seq_chunk_addsub: RTL
=====================

Name: seq_chunk_addsub

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the 4-bit combinational ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, reusing one CHUNK-bit ripple-carry slice across cycles.
- Carries the registered carry between chunks and reports carry, signed overflow and zero flags.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per RUN cycle; must be 1..WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, mod 2^WIDTH.
- cout  output  1  final carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (reset_n low, any time, including mid-RUN):
  - state=IDLE; in_ready=1; out_valid=0; result=0; cout=0; ovf=0; zero=0.
  - Chunk index and carry register cleared; any in-flight operation is discarded.
- FSM states IDLE, RUN, DONE:
  - in_ready = (state==IDLE), combinational from state.
  - out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid & in_ready at a clock edge, capture a, b, sub and cin into internal registers.
  - If sub=1, B is stored inverted.
  - Carry register <= cin ^ sub. Chunk index <= 0. Go to RUN.
  - No transition without in_valid.
- RUN, one chunk per cycle, i = 0..NCHUNK-1:
  - Compute {c, s} = A[i] + B'[i] + carry over bits [i*CHUNK +: CHUNK].
  - Write s into result[i*CHUNK +: CHUNK]. carry <= c.
  - On i == NCHUNK-1, also:
    - cout <= c.
    - ovf <= (carry into MSB) ^ c.
    - zero <= (completed result == 0), evaluated on the final value including the last chunk.
    - Go to DONE.
  - Input changes during RUN have no effect; operands are held in registers.
- DONE:
  - result/cout/ovf/zero held stable while out_valid=1 and out_ready=0, for unbounded backpressure.
  - On out_ready=1, go to IDLE; outputs keep their values, but out_valid=0.
- Latency and throughput:
  - Input handshake at edge k gives out_valid=1 after edge k+NCHUNK.
  - Minimum spacing between accepted operations is NCHUNK+2 cycles.
  - A new operation cannot be accepted in the same cycle the result is taken.
- result is partially updated during RUN; consumers sample only when out_valid=1.
- Arithmetic is mod 2^WIDTH; no saturation.
- CHUNK == WIDTH: RUN lasts exactly one cycle, so latency is 1.

Test Plan:
- WIDTH=16, CHUNK=4: add a=0x1234, b=0x4321, cin=0 -> out_valid exactly 4 cycles after handshake; result=0x5555, cout=0, ovf=0, zero=0.
- Add a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, ovf=0, zero=1. Add a=0x7FFF, b=0x0001 -> result=0x8000, cout=0, ovf=1.
- Sub a=0x0005, b=0x0007, cin=0 -> result=0xFFFE, cout=0, ovf=0. Sub a=0x8000, b=0x0001, cin=1 -> result=0x7FFE, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and flags constant, in_ready=0, changing a/b has no effect. Release -> IDLE next cycle, in_ready=1.
- Reset: assert reset_n=0 during the 2nd RUN cycle -> all outputs 0 and in_ready=1 immediately (asynchronous). A new add 0x0001+0x0001 afterwards -> result=0x0002.
- Parameter sweep CHUNK=1, 4, 16 with 200 random a/b/sub/cin -> every result/cout/ovf/zero matches the reference model; latency equals 16, 4 and 1 respectively.

Source files
------------

// File: rtl/seq_chunk_addsub.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_addsub
// Description : Multi-cycle adder/subtractor. Processes a WIDTH-bit add or
//               subtract CHUNK bits per clock through a single CHUNK-bit
//               ripple slice, carrying the registered carry between chunks.
//               Reports final carry (no-borrow for subtract), signed
//               overflow and zero flags. Valid/ready handshakes on both the
//               operand side and the result side.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   operands and mode valid
//   in_ready  out  block idle, can accept an operation
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in (add) / borrow-in (sub)
//   sub       in   0: A+B+cin, 1: A-B-cin
//   out_valid out  result fields valid
//   out_ready in   consumer accepts result
//   result    out  sum/difference mod 2^WIDTH
//   cout      out  carry out of MSB (sub: 1 = no borrow)
//   ovf       out  signed two's-complement overflow
//   zero      out  result == 0
// ============================================================================
module seq_chunk_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Shared ripple slice
  int               base_w;
  logic [CHUNK-1:0] a_chunk_w;
  logic [CHUNK-1:0] b_chunk_w;
  logic [CHUNK:0]   sum_w;
  logic             msb_cin_w;
  logic [WIDTH-1:0] result_merged_w;
  logic             last_w;

  always_comb begin
    base_w          = int'(idx_q) * CHUNK;
    a_chunk_w       = a_q[base_w +: CHUNK];
    b_chunk_w       = b_q[base_w +: CHUNK];
    sum_w           = {1'b0, a_chunk_w} + {1'b0, b_chunk_w} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from that bit's sum.
    msb_cin_w       = a_chunk_w[CHUNK-1] ^ b_chunk_w[CHUNK-1] ^ sum_w[CHUNK-1];
    // Result as it will look after this chunk is written; the zero flag
    // must see the final chunk, not the stale register contents.
    result_merged_w = result_q;
    result_merged_w[base_w +: CHUNK] = sum_w[CHUNK-1:0];
    last_w          = (idx_q == IDXW'(NCHUNK - 1));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtract is A + ~B + 1; borrow-in removes that +1.
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d = result_merged_w;
        carry_d  = sum_w[CHUNK];
        if (last_w) begin
          cout_d  = sum_w[CHUNK];
          ovf_d   = msb_cin_w ^ sum_w[CHUNK];
          zero_d  = (result_merged_w == '0);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire
